// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - recovers pixel coordinates, line/frame geometry and lock from a DVI de/vsync stream
module video_timing_detector #(
    parameter int CW          = 11,
    parameter int HPIXELS     = 640,
    parameter int VLINES      = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rstbtn_n,
    input  logic          de,
    input  logic          hsync,
    input  logic          vsync,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          sof,
    output logic          eol,
    output logic [CW-1:0] meas_hpix,
    output logic [CW-1:0] meas_vlines,
    output logic          locked,
    output logic          err
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam int            GW   = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] HP   = CW'(HPIXELS);
    localparam logic [CW-1:0] VL   = CW'(VLINES);
    localparam logic [GW-1:0] LF   = GW'(LOCK_FRAMES);

    state_t        r_state;
    logic [GW-1:0] r_good_cnt;
    logic          r_de_q, r_vs_q, r_abort;
    logic [CW-1:0] r_x_cnt, r_y_cnt, r_meas_hpix, r_meas_vlines;
    logic          r_eol, r_sof, r_err, r_locked;

    state_t        w_state_next;
    logic [GW-1:0] w_good_next;
    logic          w_err_next;
    logic          w_de_rise, w_de_fall, w_vs_rise, w_viol, w_line_end;
    logic          w_line_bad, w_frame_bad, w_sof_next;
    logic [CW-1:0] w_len, w_y_inc, w_lines;
    logic          w_unused_hsync;

    assign w_unused_hsync = hsync;

    assign w_de_rise  = de & ~r_de_q;
    assign w_de_fall  = ~de & r_de_q;
    assign w_vs_rise  = vsync & ~r_vs_q;
    assign w_viol     = w_vs_rise & de;
    // A line cut by vsync is never closed, so its de fall is not measured
    assign w_line_end = w_de_fall & ~r_abort;

    assign w_len   = (r_x_cnt == CMAX) ? CMAX : r_x_cnt + 1'b1;
    assign w_y_inc = (r_y_cnt == CMAX) ? CMAX : r_y_cnt + 1'b1;
    assign w_lines = w_line_end ? w_y_inc : r_y_cnt;

    assign w_line_bad  = w_line_end & ((w_len != HP) | (r_x_cnt == CMAX));
    assign w_frame_bad = (w_lines != VL) | (w_lines == CMAX);

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_err_next   = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vs_rise && !w_viol) begin
                    w_state_next = MEASURE;
                    w_good_next  = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (w_viol || w_line_bad || (w_vs_rise && w_frame_bad)) begin
                    w_err_next   = 1'b1;
                    w_state_next = SEARCH;
                end else if (w_vs_rise && r_state == MEASURE) begin
                    w_good_next = r_good_cnt + 1'b1;
                    if (r_good_cnt + 1'b1 == LF) begin
                        w_state_next = LOCKED;
                    end
                end
            end
            default: w_state_next = SEARCH;
        endcase
    end

    // Same condition as pix_valid & pix_x==0 & pix_y==0 & state!=SEARCH, one cycle early
    assign w_sof_next = de & (w_viol | w_de_rise) & (w_vs_rise | (r_y_cnt == '0))
                        & (w_state_next != SEARCH);

    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_state       <= SEARCH;
            r_good_cnt    <= '0;
            r_de_q        <= 1'b0;
            r_vs_q        <= 1'b0;
            r_abort       <= 1'b0;
            r_x_cnt       <= '0;
            r_y_cnt       <= '0;
            r_meas_hpix   <= '0;
            r_meas_vlines <= '0;
            r_eol         <= 1'b0;
            r_sof         <= 1'b0;
            r_err         <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
            r_de_q     <= de;
            r_vs_q     <= vsync;
            r_eol      <= w_de_fall;
            r_sof      <= w_sof_next;
            r_err      <= w_err_next;
            r_locked   <= (w_state_next == LOCKED);

            if (w_viol) begin
                r_x_cnt <= '0;
                r_abort <= 1'b1;
            end else if (w_de_rise) begin
                r_x_cnt <= '0;
                r_abort <= 1'b0;
            end else if (de && r_x_cnt != CMAX) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end

            if (w_line_end) begin
                r_meas_hpix <= w_len;
            end

            if (w_vs_rise) begin
                r_meas_vlines <= w_lines;
                r_y_cnt       <= '0;
            end else if (w_line_end) begin
                r_y_cnt <= w_y_inc;
            end
        end
    end

    assign pix_valid   = r_de_q;
    assign pix_x       = r_x_cnt;
    assign pix_y       = r_y_cnt;
    assign sof         = r_sof;
    assign eol         = r_eol;
    assign meas_hpix   = r_meas_hpix;
    assign meas_vlines = r_meas_vlines;
    assign locked      = r_locked;
    assign err         = r_err;

endmodule

// File: tb/tb_video_timing_detector.sv
// tb/tb_video_timing_detector.sv - directed vector bench for video_timing_detector on a reduced 8x4 mode
module tb_video_timing_detector;

    localparam int CW = 11;
    localparam int HP = 8;
    localparam int VL = 4;
    localparam int LF = 2;

    logic          clk, rstbtn_n, de, hsync, vsync;
    logic          pix_valid, sof, eol, locked, err;
    logic [CW-1:0] pix_x, pix_y, meas_hpix, meas_vlines;

    int n_checks = 0;
    int n_errors = 0;
    int n_errp   = 0;
    int n_sof    = 0;
    int e0, s0;

    video_timing_detector #(.CW(CW), .HPIXELS(HP), .VLINES(VL), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rstbtn_n(rstbtn_n), .de(de), .hsync(hsync), .vsync(vsync),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol),
        .meas_hpix(meas_hpix), .meas_vlines(meas_vlines), .locked(locked), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstbtn_n) begin
            if (err) n_errp++;
            if (sof) n_sof++;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic de;
        logic vs;
        int   pv, x, y, eol, sof, err, hpix, vl;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            tick();
        end
        de    = 1'b0;
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic vs_begin();
        vsync = 1'b1;
        tick();
    endtask

    task automatic vs_end();
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_vs();
        vs_begin();
        vs_end();
    endtask

    task automatic good_lines(input int n);
        for (int i = 0; i < n; i++) send_line(HP);
    endtask

    task automatic do_reset();
        rstbtn_n = 1'b0;
        de = 1'b0;
        vsync = 1'b0;
        hsync = 1'b0;
        tick();
        tick();
        rstbtn_n = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1, 2, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 0, 2, 1, 1, 0, 0, 3, 0};
        vecs[5]  = '{1'b0, 1'b0, 0, 2, 1, 0, 0, 0, 3, 0};
        vecs[6]  = '{1'b0, 1'b1, 0, 2, 0, 0, 0, 0, 3, 1};
        vecs[7]  = '{1'b0, 1'b1, 0, 2, 0, 0, 0, 0, 3, 1};
        vecs[8]  = '{1'b1, 1'b0, 1, 0, 0, 0, 1, 0, 3, 1};
        vecs[9]  = '{1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 3, 1};
        vecs[10] = '{1'b0, 1'b0, 0, 1, 1, 1, 0, 1, 2, 1};
        vecs[11] = '{1'b0, 1'b0, 0, 1, 1, 0, 0, 0, 2, 1};

        rstbtn_n = 1'b0;
        de = 1'b0;
        vsync = 1'b0;
        hsync = 1'b0;
        tick();
        tick();
        chk("reset_outputs", int'({pix_valid, pix_x, pix_y, sof, eol, meas_hpix,
                                   meas_vlines, locked, err} != '0), 0);
        rstbtn_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            de    = vecs[i].de;
            vsync = vecs[i].vs;
            tick();
            chk($sformatf("vec%0d_pix_valid", i), pix_valid, vecs[i].pv);
            chk($sformatf("vec%0d_pix_x", i), pix_x, vecs[i].x);
            chk($sformatf("vec%0d_pix_y", i), pix_y, vecs[i].y);
            chk($sformatf("vec%0d_eol", i), eol, vecs[i].eol);
            chk($sformatf("vec%0d_sof", i), sof, vecs[i].sof);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
            chk($sformatf("vec%0d_meas_hpix", i), meas_hpix, vecs[i].hpix);
            chk($sformatf("vec%0d_meas_vlines", i), meas_vlines, vecs[i].vl);
        end

        // Lock acquisition: unaligned first frame, then three vsync edges
        do_reset();
        e0 = n_errp;
        s0 = n_sof;
        good_lines(VL);
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(VL);
        chk("t1_locked_before", locked, 0);
        vs_begin();
        chk("t1_locked_after_3rd_vs", locked, 1);
        vs_end();
        good_lines(VL);
        chk("t1_sof_count", n_sof - s0, 3);
        chk("t1_err_count", n_errp - e0, 0);
        chk("t1_meas_vlines", meas_vlines, VL);
        chk("t1_meas_hpix", meas_hpix, HP);

        // Short line while locked, then relock
        send_vs();
        chk("t2_still_locked", locked, 1);
        e0 = n_errp;
        for (int i = 0; i < HP - 1; i++) begin
            de = 1'b1;
            tick();
        end
        de = 1'b0;
        tick();
        chk("t2_err_pulse", err, 1);
        chk("t2_meas_hpix", meas_hpix, HP - 1);
        chk("t2_unlocked", locked, 0);
        tick();
        chk("t2_err_one_cycle", err, 0);
        tick();
        tick();
        good_lines(VL - 1);
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(VL);
        vs_begin();
        chk("t2_relocked", locked, 1);
        vs_end();
        chk("t2_err_count", n_errp - e0, 1);

        // Short frame
        good_lines(VL - 1);
        vs_begin();
        chk("t3_err_pulse", err, 1);
        chk("t3_meas_vlines", meas_vlines, VL - 1);
        chk("t3_unlocked", locked, 0);
        tick();
        chk("t3_err_one_cycle", err, 0);
        vsync = 1'b0;
        tick();
        tick();
        s0 = n_sof;
        good_lines(VL);
        chk("t3_search_no_sof", n_sof - s0, 0);

        // de fall coincident with vsync rise on the last line
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(VL - 1);
        e0 = n_errp;
        for (int i = 0; i < HP; i++) begin
            de = 1'b1;
            tick();
        end
        de = 1'b0;
        vsync = 1'b1;
        tick();
        chk("t4_meas_vlines", meas_vlines, VL);
        chk("t4_meas_hpix", meas_hpix, HP);
        chk("t4_locked", locked, 1);
        chk("t4_eol", eol, 1);
        vs_end();
        chk("t4_no_err", n_errp - e0, 0);

        // vsync rising inside an active line
        good_lines(2);
        for (int i = 0; i < 3; i++) begin
            de = 1'b1;
            tick();
        end
        vsync = 1'b1;
        tick();
        chk("t5_err_pulse", err, 1);
        chk("t5_unlocked", locked, 0);
        chk("t5_pix_x_cleared", pix_x, 0);
        tick();
        vsync = 1'b0;
        tick();
        de = 1'b0;
        tick();
        chk("t5_meas_hpix_unchanged", meas_hpix, HP);
        chk("t5_pix_y_not_counted", pix_y, 0);
        repeat (3) tick();
        de = 1'b1;
        tick();
        chk("t5_restart_valid", pix_valid, 1);
        chk("t5_restart_x0", pix_x, 0);
        tick();
        chk("t5_restart_x1", pix_x, 1);
        send_line(HP - 2);

        // Asynchronous reset pulse mid-line
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(1);
        for (int i = 0; i < 3; i++) begin
            de = 1'b1;
            tick();
        end
        chk("t6_locked_before_reset", locked, 1);
        rstbtn_n = 1'b0;
        #1;
        chk("t6_async_outputs_zero", int'({pix_valid, pix_x, pix_y, sof, eol, meas_hpix,
                                           meas_vlines, locked, err} != '0), 0);
        tick();
        rstbtn_n = 1'b1;
        e0 = n_errp;
        s0 = n_sof;
        send_line(2);
        good_lines(2);
        chk("t6_no_sof_before_vs", n_sof - s0, 0);
        chk("t6_no_err_before_vs", n_errp - e0, 0);
        chk("t6_not_locked", locked, 0);
        send_vs();
        good_lines(VL);
        send_vs();
        good_lines(VL);
        vs_begin();
        chk("t6_relocked", locked, 1);
        vs_end();

        // Saturating line length
        for (int i = 0; i < 2050; i++) begin
            de = 1'b1;
            tick();
        end
        de = 1'b0;
        tick();
        chk("sat_err", err, 1);
        chk("sat_meas_hpix", meas_hpix, 2047);
        chk("sat_unlocked", locked, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
